// File: rtl/bios_pkg.sv
// bios_pkg: state encoding and constants shared by the bios loader
package bios_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;
    localparam logic [1:0] BE_WORD = 2'b11;
endpackage

// File: rtl/bios_loader.sv
// bios_loader: copies LEN words from bios ROM to main RAM at boot, holding the CPU until done
module bios_loader
    import bios_pkg::*;
#(
    parameter int unsigned LEN        = 4096,
    parameter logic [15:0] SRC_BASE   = 16'h0000,
    parameter logic [15:0] DST_BASE   = 16'h0000,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [15:0] rom_addr,
    output logic [1:0]  rom_be,
    output logic        rom_ce,
    input  logic [15:0] rom_data,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_wdata,
    output logic        ram_we,
    input  logic        ram_ack,
    output logic        busy,
    output logic        done,
    output logic        cpu_hold,
    output logic [15:0] checksum
);
    localparam logic [16:0] LAST = 17'(LEN - 1);
    state_t      state;
    logic [16:0] idx;
    logic        first;
    logic        go;
    assign rom_be = BE_WORD;
    // first is high only in the cycle right after reset releases, giving the auto-start pulse
    assign go = start || (AUTO_START && first);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            first     <= 1'b1;
            rom_addr  <= SRC_BASE;
            rom_ce    <= 1'b0;
            ram_addr  <= DST_BASE;
            ram_wdata <= '0;
            ram_we    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cpu_hold  <= 1'b1;
            checksum  <= '0;
        end else begin
            first <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (go && LEN == 0) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else if (go) begin
                        state    <= READ;
                        idx      <= '0;
                        checksum <= '0;
                        done     <= 1'b0;
                        cpu_hold <= 1'b1;
                        busy     <= 1'b1;
                        rom_ce   <= 1'b1;
                        rom_addr <= SRC_BASE;
                    end
                end
                READ: begin
                    state     <= WRITE;
                    rom_ce    <= 1'b0;
                    ram_wdata <= rom_data;
                    ram_addr  <= DST_BASE + idx[15:0];
                    ram_we    <= 1'b1;
                end
                WRITE: begin
                    if (ram_ack) begin
                        ram_we   <= 1'b0;
                        checksum <= checksum + ram_wdata;
                        if (idx == LAST) begin
                            state    <= DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state    <= READ;
                            idx      <= idx + 17'd1;
                            rom_ce   <= 1'b1;
                            rom_addr <= SRC_BASE + idx[15:0] + 16'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bios_loader.sv
// tb_bios_loader: scoreboard bench driving three loader configurations against a ROM and RAM responder model
module tb_bios_loader;
    typedef struct {
        int          id;
        logic [15:0] a;
        logic [15:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start     [3];
    logic [15:0] rom_addr  [3];
    logic [1:0]  rom_be    [3];
    logic        rom_ce    [3];
    logic [15:0] rom_data  [3];
    logic [15:0] ram_addr  [3];
    logic [15:0] ram_wdata [3];
    logic        ram_we    [3];
    logic        busy      [3];
    logic        done      [3];
    logic        cpu_hold  [3];
    logic [15:0] checksum  [3];
    logic        ram_ack;
    logic        we_any;
    int          ack_dly = 0;
    int          wcnt = 0;
    int          n_chk = 0;
    int          n_err = 0;
    ent_t        rq[$];
    ent_t        wq[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign rom_data[g] = rom_addr[g] ^ 16'hA5A5;
        bios_loader #(
            .LEN       (g == 0 ? 4 : g == 1 ? 3 : 0),
            .SRC_BASE  (g == 1 ? 16'hFFFE : 16'h0000),
            .DST_BASE  (16'h0000),
            .AUTO_START(g == 0)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .start    (start[g]),
            .rom_addr (rom_addr[g]),
            .rom_be   (rom_be[g]),
            .rom_ce   (rom_ce[g]),
            .rom_data (rom_data[g]),
            .ram_addr (ram_addr[g]),
            .ram_wdata(ram_wdata[g]),
            .ram_we   (ram_we[g]),
            .ram_ack  (ram_ack),
            .busy     (busy[g]),
            .done     (done[g]),
            .cpu_hold (cpu_hold[g]),
            .checksum (checksum[g])
        );
    end

    // RAM responder: acks once ram_we has been high for ack_dly cycles
    assign we_any  = ram_we[0] | ram_we[1] | ram_we[2];
    assign ram_ack = we_any && (wcnt == ack_dly);
    always @(posedge clk) wcnt <= (we_any && !ram_ack) ? wcnt + 1 : 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(string name);
        n_chk++;
        n_err++;
        $display("FAIL %s: got activity expected none", name);
    endtask

    function automatic logic [15:0] csum(int len, logic [15:0] src);
        logic [15:0] s = '0;
        for (int k = 0; k < len; k++) s = s + ((src + 16'(k)) ^ 16'hA5A5);
        return s;
    endfunction

    task automatic push_run(int id, int len, logic [15:0] src, logic [15:0] dst);
        for (int k = 0; k < len; k++) begin
            rq.push_back('{id, src + 16'(k), 16'h0});
            wq.push_back('{id, dst + 16'(k), (src + 16'(k)) ^ 16'hA5A5});
        end
    endtask

    task automatic pulse_start(int id);
        start[id] = 1'b1;
        @(posedge clk);
        #1 start[id] = 1'b0;
    endtask

    task automatic wait_done(int id, int max, output int cyc);
        cyc = 0;
        while (cyc < max) begin
            @(posedge clk);
            #1 cyc++;
            if (done[id]) break;
        end
        check($sformatf("done_seen%0d", id), 32'(done[id]), 1);
    endtask

    task automatic chk_reset(int id, logic [15:0] src);
        check("rst_rom_addr", rom_addr[id], src);
        check("rst_rom_ce", rom_ce[id], 0);
        check("rst_ram_addr", ram_addr[id], 0);
        check("rst_ram_wdata", ram_wdata[id], 0);
        check("rst_ram_we", ram_we[id], 0);
        check("rst_busy", busy[id], 0);
        check("rst_done", done[id], 0);
        check("rst_cpu_hold", cpu_hold[id], 1);
        check("rst_checksum", checksum[id], 0);
    endtask

    // monitor: pops expected reads/writes as the DUTs present them
    ent_t        me;
    int          wcyc = 0;
    logic        pend = 1'b0;
    logic [15:0] pa, pd;
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rom_ce[i]) begin
                check("rom_be", rom_be[i], 2'b11);
                if (rq.size() == 0) unexpected("rom_read");
                else begin
                    me = rq.pop_front();
                    check("rom_id", i, me.id);
                    check("rom_addr", rom_addr[i], me.a);
                end
            end
            if (ram_we[i]) begin
                if (pend) begin
                    check("hold_addr", ram_addr[i], pa);
                    check("hold_data", ram_wdata[i], pd);
                end
                wcyc++;
                if (ram_ack) begin
                    check("we_cycles", wcyc, ack_dly + 1);
                    if (wq.size() == 0) unexpected("ram_write");
                    else begin
                        me = wq.pop_front();
                        check("wr_id", i, me.id);
                        check("wr_addr", ram_addr[i], me.a);
                        check("wr_data", ram_wdata[i], me.d);
                    end
                    wcyc = 0;
                    pend = 1'b0;
                end else begin
                    pend = 1'b1;
                    pa   = ram_addr[i];
                    pd   = ram_wdata[i];
                end
            end
        end
    end

    initial begin
        int cyc;
        int k;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) start[i] = 1'b0;
        // auto-start copy of 4 words with immediate ack
        push_run(0, 4, 16'h0000, 16'h0000);
        repeat (2) @(posedge clk);
        #1 chk_reset(0, 16'h0000);
        check("rst_rom_addr1", rom_addr[1], 16'hFFFE);
        rst = 1'b0;
        wait_done(0, 50, cyc);
        check("done_cycle", cyc, 9);
        check("checksum_a", checksum[0], csum(4, 16'h0000));
        check("cpu_hold_a", cpu_hold[0], 0);
        check("busy_a", busy[0], 0);
        check("wq_empty_a", wq.size(), 0);
        // delayed ack, plus a start that lands on an ack cycle mid-copy
        ack_dly = 3;
        push_run(0, 4, 16'h0000, 16'h0000);
        pulse_start(0);
        check("busy_b", busy[0], 1);
        check("done_clr_b", done[0], 0);
        check("cpu_hold_b", cpu_hold[0], 1);
        check("checksum_clr_b", checksum[0], 0);
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            #1;
            if (ram_we[0] && ram_ack) break;
        end
        check("ack_seen", 32'(ram_we[0] && ram_ack), 1);
        start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        check("busy_ignored", busy[0], 1);
        wait_done(0, 100, cyc);
        check("checksum_b", checksum[0], csum(4, 16'h0000));
        check("wq_empty_b", wq.size(), 0);
        // source address wrap on a start-triggered instance
        ack_dly = 1;
        push_run(1, 3, 16'hFFFE, 16'h0000);
        pulse_start(1);
        wait_done(1, 50, cyc);
        check("checksum_c", checksum[1], csum(3, 16'hFFFE));
        check("cpu_hold_c", cpu_hold[1], 0);
        check("wq_empty_c", wq.size(), 0);
        // zero-length copy completes on the next cycle with no bus activity
        pulse_start(2);
        check("done_d", done[2], 1);
        check("cpu_hold_d", cpu_hold[2], 0);
        check("busy_d", busy[2], 0);
        repeat (3) @(posedge clk);
        // asynchronous reset during word 2, then automatic restart
        ack_dly = 0;
        push_run(0, 4, 16'h0000, 16'h0000);
        pulse_start(0);
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            #1;
            if (rom_ce[0] && rom_addr[0] == 16'h0002) break;
        end
        check("word2_seen", 32'(rom_ce[0] && rom_addr[0] == 16'h0002), 1);
        #1 rst = 1'b1;
        #1 chk_reset(0, 16'h0000);
        rq.delete();
        wq.delete();
        push_run(0, 4, 16'h0000, 16'h0000);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_done(0, 50, cyc);
        check("done_cycle_e", cyc, 9);
        check("checksum_e", checksum[0], csum(4, 16'h0000));
        check("wq_empty_e", wq.size(), 0);
        check("rq_empty_e", rq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
